// File: rtl/vector_stream_engine.sv
// vector_stream_engine: point FIFO feeding a Bresenham line walker that emits X/Y/Z DAC words.
// Blanked points jump the beam with intensity 0; drawn points step one pixel per emitted triple.
module vector_stream_engine #(
    parameter int WIDTH   = 12,
    parameter int Z_WIDTH = 8,
    parameter int DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_y,
    input  logic [Z_WIDTH-1:0]       in_z,
    input  logic                     in_blank,
    output logic                     dac_valid,
    input  logic                     dac_ready,
    output logic [1:0]               dac_chan,
    output logic [WIDTH-1:0]         dac_value,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * WIDTH + Z_WIDTH + 1;
    localparam int SW = WIDTH + 2;

    typedef enum logic [2:0] {IDLE, LOAD, STEP, BLANK_Z, EMIT_X, EMIT_Y, EMIT_Z} state_t;
    state_t state, next;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    logic [WIDTH-1:0] px, py, tx, ty, abs_x, abs_y;
    logic [Z_WIDTH-1:0] tz;
    logic tb, sx, sy, at_target, step_x, step_y;
    logic signed [SW-1:0] dx, dy, err, ld_dx, ld_dy;
    logic signed [SW:0] e2;

    assign in_ready  = level != (AW + 1)'(DEPTH);
    assign push      = in_valid && in_ready;
    assign pop       = state == IDLE && level != '0;
    assign busy      = level != '0 || state != IDLE;
    assign at_target = px == tx && py == ty;
    assign abs_x     = tx > px ? tx - px : px - tx;
    assign abs_y     = ty > py ? ty - py : py - ty;
    assign ld_dx     = SW'(abs_x);
    assign ld_dy     = -SW'(abs_y);
    // e2 is one bit wider than err so doubling never overflows the comparison
    assign e2        = (SW + 1)'(err) <<< 1;
    assign step_x    = e2 >= (SW + 1)'(dy);
    assign step_y    = e2 <= (SW + 1)'(dx);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {in_x, in_y, in_z, in_blank};

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    always_ff @(posedge clk)
        state <= reset ? IDLE : next;

    always_ff @(posedge clk) begin
        if (reset) begin
            px <= '0;
            py <= '0;
        end else if (state == IDLE && pop) begin
            {tx, ty, tz, tb} <= mem[rd_ptr];
        end else if (state == LOAD && tb) begin
            px <= tx;
            py <= ty;
        end else if (state == LOAD) begin
            dx  <= ld_dx;
            dy  <= ld_dy;
            err <= ld_dx + ld_dy;
            sx  <= tx > px;
            sy  <= ty > py;
        end else if (state == STEP && !at_target) begin
            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
            if (step_x) px <= sx ? px + 1'b1 : px - 1'b1;
            if (step_y) py <= sy ? py + 1'b1 : py - 1'b1;
        end
    end

    always_comb begin
        next      = state;
        dac_valid = 1'b0;
        dac_chan  = 2'd0;
        dac_value = '0;
        case (state)
            IDLE:    next = pop ? LOAD : IDLE;
            LOAD:    next = tb ? BLANK_Z : STEP;
            STEP:    next = EMIT_X;
            BLANK_Z: begin
                dac_valid = 1'b1;
                dac_chan  = 2'd2;
                next      = dac_ready ? EMIT_X : BLANK_Z;
            end
            EMIT_X:  begin
                dac_valid = 1'b1;
                dac_value = px;
                next      = dac_ready ? EMIT_Y : EMIT_X;
            end
            EMIT_Y:  begin
                dac_valid = 1'b1;
                dac_chan  = 2'd1;
                dac_value = py;
                next      = !dac_ready ? EMIT_Y : tb ? IDLE : EMIT_Z;
            end
            EMIT_Z:  begin
                dac_valid = 1'b1;
                dac_chan  = 2'd2;
                dac_value = WIDTH'(tz);
                next      = !dac_ready ? EMIT_Z : at_target ? IDLE : STEP;
            end
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vector_stream_engine.sv
// tb_vector_stream_engine: table-driven point vectors with a word scoreboard for vector_stream_engine.
// Expected DAC words are queued when points are pushed and popped as the DUT hands them over.
module tb_vector_stream_engine;
    logic clk = 0, reset = 1, in_valid = 0, in_blank = 0, dac_ready;
    logic [11:0] in_x = 0, in_y = 0, dac_value;
    logic [7:0] in_z = 0;
    logic in_ready, dac_valid, busy;
    logic [1:0] dac_chan;
    logic [4:0] level;

    vector_stream_engine dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_blank(in_blank),
        .dac_valid(dac_valid), .dac_ready(dac_ready), .dac_chan(dac_chan),
        .dac_value(dac_value), .busy(busy), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit [11:0] x, y;
        bit [7:0] z;
        bit blank;
        int n;
    } pt_t;

    int n_vec = 0, n_bad = 0, ready_mode = 1;
    logic [13:0] sb[$];
    logic [13:0] ew[$];
    pt_t pts[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic w(input int ch, input int v);
        ew.push_back({2'(ch), 12'(v)});
    endtask

    task automatic push(input int x, input int y, input int z, input bit b);
        in_x = 12'(x); in_y = 12'(y); in_z = 8'(z); in_blank = b; in_valid = 1;
        chk("push_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic do_reset(input string nm);
        reset = 1;
        @(posedge clk); #1;
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_dac_valid"}, dac_valid, 0);
        chk({nm, "_dac_chan"}, dac_chan, 0);
        chk({nm, "_dac_value"}, dac_value, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_level"}, level, 0);
        reset = 0;
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while ((sb.size() != 0 || busy) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        chk({nm, "_words_left"}, sb.size(), 0);
        chk({nm, "_busy_end"}, busy, 0);
    endtask

    // DAC-side handshake driver
    initial begin
        dac_ready = 1;
        forever begin
            @(posedge clk); #1;
            dac_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
        end
    end

    // Word monitor: a word seen valid&&ready here is taken on the next rising edge
    logic prev_stall = 0;
    logic [13:0] prev_word;
    logic [13:0] exp_word;
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (!dac_valid || {dac_chan, dac_value} != prev_word) begin
                    n_bad++;
                    $display("FAIL stall_hold: got v=%0d ch=%0d val=%0d expected ch=%0d val=%0d",
                             dac_valid, dac_chan, dac_value, prev_word[13:12], prev_word[11:0]);
                end
            end
            if (dac_valid && dac_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL word_extra: got ch=%0d val=%0d expected no word", dac_chan, dac_value);
                end else begin
                    exp_word = sb.pop_front();
                    if ({dac_chan, dac_value} != exp_word) begin
                        n_bad++;
                        $display("FAIL word: got ch=%0d val=%0d expected ch=%0d val=%0d",
                                 dac_chan, dac_value, exp_word[13:12], exp_word[11:0]);
                    end
                end
            end
            prev_stall = dac_valid && !dac_ready;
            prev_word  = {dac_chan, dac_value};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k = 0;
        int c;
        pts[0] = '{1, 3, 1, 8'h80, 0, 9};
        w(0, 1); w(1, 0); w(2, 8'h80); w(0, 2); w(1, 1); w(2, 8'h80); w(0, 3); w(1, 1); w(2, 8'h80);
        pts[1] = '{0, 100, 200, 0, 1, 3};
        w(2, 0); w(0, 100); w(1, 200);
        pts[2] = '{0, 100, 202, 8'hFF, 0, 6};
        w(0, 100); w(1, 201); w(2, 8'hFF); w(0, 100); w(1, 202); w(2, 8'hFF);
        pts[3] = '{1, 0, 0, 5, 0, 3};
        w(0, 0); w(1, 0); w(2, 5);
        pts[4] = '{0, 4095, 4095, 0, 1, 3};
        w(2, 0); w(0, 4095); w(1, 4095);
        pts[5] = '{0, 4093, 4095, 1, 0, 6};
        w(0, 4094); w(1, 4095); w(2, 1); w(0, 4093); w(1, 4095); w(2, 1);

        @(posedge clk); #1;
        do_reset("reset0");

        for (int r = 0; r < 6; r++) begin
            if (pts[r].rst) do_reset("reset_row");
            for (int j = 0; j < pts[r].n; j++) sb.push_back(ew[k++]);
            push(pts[r].x, pts[r].y, pts[r].z, pts[r].blank);
            if (pts[r].rst) begin
                chk("lat_n0", dac_valid, 0);
                @(posedge clk); #1; chk("lat_n1", dac_valid, 0);
                @(posedge clk); #1; chk("lat_n2", dac_valid, 0);
                @(posedge clk); #1; chk("lat_n3", dac_valid, 1);
            end
            drain("row");
        end

        // Diagonal under random backpressure: same words as an unstalled run
        do_reset("reset_bp");
        ready_mode = 2;
        for (int i = 1; i <= 8; i++) begin
            sb.push_back({2'd0, 12'(i)});
            sb.push_back({2'd1, 12'(i)});
            sb.push_back({2'd2, 12'd7});
        end
        push(8, 8, 7, 0);
        drain("backpressure");
        ready_mode = 1;

        // Fill the FIFO with the DAC stalled: one point is in the engine, 16 queue, the last drops
        ready_mode = 0;
        do_reset("reset_full");
        for (int i = 0; i < 18; i++) begin
            in_x = 12'(i * 100 + 1); in_y = 12'(i * 50 + 2); in_z = 0; in_blank = 1; in_valid = 1;
            chk("full_in_ready", in_ready, i < 17);
            if (i < 17) begin
                sb.push_back({2'd2, 12'd0});
                sb.push_back({2'd0, 12'(i * 100 + 1)});
                sb.push_back({2'd1, 12'(i * 50 + 2)});
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        chk("full_level", level, 16);
        chk("full_in_ready_end", in_ready, 0);
        ready_mode = 1;
        drain("full");

        // Reset during EMIT_Y of a long line discards the line and the queued point
        do_reset("reset_mid0");
        for (int i = 1; i <= 50; i++) begin
            sb.push_back({2'd0, 12'(i)});
            sb.push_back({2'd1, 12'd0});
            sb.push_back({2'd2, 12'd9});
        end
        push(50, 0, 9, 0);
        push(7, 7, 0, 1);
        c = 0;
        while (!(dac_valid && dac_chan == 1 && sb.size() <= 120) && c < 1000) begin
            @(posedge clk); #1;
            c++;
        end
        chk("mid_found_emit_y", c < 1000, 1);
        sb.delete();
        do_reset("reset_mid");
        sb.push_back({2'd0, 12'd1});
        sb.push_back({2'd1, 12'd1});
        sb.push_back({2'd2, 12'd3});
        push(1, 1, 3, 0);
        drain("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/vector_stream_engine.md
# vector_stream_engine

Parametrised point-stream line engine for the vector display path. It accepts target points into a FIFO and walks a Bresenham line from the current beam position to each target, including blanked (beam-off) moves. It emits one X/Y/Z word triple per step on a valid/ready DAC-word interface. It sits between the point source and the multi-channel DAC serializer, and replaces the fixed 12-bit, single-point, two-channel drawing loop.

## Interface
- `WIDTH`, default 12: coordinate and DAC word width.
- `Z_WIDTH`, default 8: intensity width; must be ≤ `WIDTH`.
- `DEPTH`, default 16: point FIFO depth; power of two, ≥ 2.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: point available.
- `in_ready` out 1: FIFO can accept a point.
- `in_x`, `in_y` in `WIDTH`: target coordinates, unsigned.
- `in_z` in `Z_WIDTH`: beam intensity for the line.
- `in_blank` in 1: move with the beam off; no line is drawn.
- `dac_valid` out 1: output word valid.
- `dac_ready` in 1: DAC accepts the word.
- `dac_chan` out 2: output channel; 0 = X, 1 = Y, 2 = Z.
- `dac_value` out `WIDTH`: word; the Z channel carries `in_z` zero-extended.
- `busy` out 1: FIFO non-empty or state ≠ IDLE.
- `level` out clog2(`DEPTH`)+1: FIFO occupancy.

## Operation
- **FIFO**
  - A point is pushed when `in_valid && in_ready`.
  - `in_ready = (level != DEPTH)`; it is not relaxed by a same-cycle pop.
  - Each FIFO entry holds {x, y, z, blank}.
- **Beam position** (`px`, `py`) is a register; it resets to (0,0).
- **States:** IDLE, LOAD, STEP, BLANK_Z, EMIT_X, EMIT_Y, EMIT_Z.
- **IDLE:** if the FIFO is non-empty, pop into target registers (`tx`, `ty`, `tz`, `tb`) and go to LOAD.
- **LOAD, draw point (`tb = 0`):**
  - dx = |tx − px|, dy = −|ty − py|.
  - sx = +1 if tx > px, else −1; sy likewise.
  - err = dx + dy.
  - Go to STEP.
  - Signed arithmetic is `WIDTH`+2 bits wide.
- **LOAD, blank point (`tb = 1`):** set `px, py ← tx, ty`, then go to BLANK_Z.
- **STEP:**
  - If (px, py) ≠ (tx, ty): e2 = 2·err.
    - If e2 ≥ dy: err += dy, px += sx.
    - If e2 ≤ dx: err += dx, py += sy.
    - Both updates use the old e2.
  - Always go to EMIT_X.
  - A zero-length draw therefore emits exactly one triple at the current position.
- **Emit states** hold `dac_valid` = 1 with a constant `dac_chan`/`dac_value` until `dac_ready`:
  - BLANK_Z emits chan 2, value 0, then goes to EMIT_X.
  - EMIT_X emits px; EMIT_Y emits py.
  - After EMIT_Y: blank point → IDLE; draw point → EMIT_Z.
  - EMIT_Z emits tz. Afterwards, if (px, py) = (tx, ty) → IDLE, else → STEP.
- Lines are inclusive of the target and exclusive of the start, except for zero-length draws.
- Coordinates never wrap, because steps stop exactly at the target.

## Timing
- **Reset values:**
  - `in_ready` = 1, `dac_valid` = 0, `dac_chan` = 0, `dac_value` = 0.
  - `busy` = 0, `level` = 0.
  - FIFO emptied, state IDLE, (px, py) = (0,0).
- **Latency:** a push accepted at edge N into an empty, idle engine raises `dac_valid` after edge N+3.
  - Edge N+1: pop (IDLE → LOAD).
  - Edge N+2: LOAD → STEP.
  - Edge N+3: STEP → EMIT_X.
- **Throughput with `dac_ready` held high:**
  - Draw: one triple per 4 cycles (X, Y, Z, STEP).
  - Blank: 3 cycles after LOAD.
  - Each new point adds 2 cycles (IDLE, LOAD).
- **Stalls:** `dac_ready` low freezes the state, `dac_value`, Bresenham registers and position. The FIFO keeps accepting until full.
- **Push while full:** `in_valid` with `level = DEPTH` is ignored. The IDLE pop on the same edge still happens, and `level` drops by 1.
- **Simultaneous push and pop** while not full: `level` unchanged.
- **Reset mid-line:** everything returns to reset values on the next edge, including `dac_valid` low and queued points discarded.

## Test plan
- **Draw a short line.** Push draw (3,1,z=0x80) from reset.
  - Expect words X1 Y0 Z80, X2 Y1 Z80, X3 Y1 Z80, then `busy` = 0.
  - Expect the first `dac_valid` 3 cycles after the push.
- **Blank move then draw.** Push blank (100,200), then draw (100,202,z=0xFF).
  - Expect Z0 X100 Y200, X100 Y201 ZFF, X100 Y202 ZFF.
- **Zero-length draw and negative direction.**
  - Push draw (0,0,z=5) from reset; expect one triple X0 Y0 Z5.
  - Then blank (4095,4095) and draw (4093,4095,z=1); expect X4094 Y4095 Z1, X4093 Y4095 Z1 with no wrap.
- **Backpressure.** Toggle `dac_ready` pseudo-randomly during an 8-step diagonal. Expect the word sequence to match the no-stall run exactly, with `dac_value`/`dac_chan` stable while `dac_valid && !dac_ready`.
- **FIFO full.** Hold `dac_ready` = 0 and push `DEPTH`+2 points.
  - Expect `in_ready` low at `level = DEPTH`; the extra points are dropped.
  - After `dac_ready` = 1, expect all accepted points drawn in order.
- **Reset mid-line.** Assert reset during EMIT_Y of a 50-step line.
  - Expect all outputs at reset values next cycle.
  - A subsequent draw (1,1) emits X1 Y1 from origin (0,0).
